// File: rtl/cache_miss_fsm_pkg.sv
// Shared encodings for the cache miss controller: FSM state codes and RAM address-select codes.
package cache_miss_fsm_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL  = 3'd0,
        ST_IC_FILL = 3'd1,
        ST_DC_FILL = 3'd2,
        ST_DC_WB   = 3'd3
    } state_e;

    localparam logic [1:0] RAM_SEL_IC    = 2'b00;
    localparam logic [1:0] RAM_SEL_DC    = 2'b01;
    localparam logic [1:0] RAM_SEL_DC_WB = 2'b11;

endpackage

// File: rtl/cache_miss_fsm_if.sv
// CPU, I/D-cache and RAM-port signals of the miss controller.
// master = controller side, slave = caches/CPU/RAM side.
interface cache_miss_fsm_if #(
    parameter int WORDS_PER_LINE = 8
);
    localparam int CNT_W = $clog2(WORDS_PER_LINE);

    logic             ic_read;
    logic             dc_read;
    logic             dc_write_in;
    logic [CNT_W-1:0] ic_word_sel_in;
    logic [CNT_W-1:0] dc_word_sel_in;
    logic [3:0]       dc_byte_w_en_in;
    logic             ic_hit;
    logic             ic_valid;
    logic             dc_hit;
    logic             dc_valid;
    logic             dc_dirty;
    logic             ram_ack;

    logic             ic_enable;
    logic             ic_cmp;
    logic             ic_write;
    logic             ic_valid_out;
    logic [CNT_W-1:0] ic_word_sel;
    logic [3:0]       ic_byte_w_en;
    logic             ic_fill_src;
    logic             dc_enable;
    logic             dc_cmp;
    logic             dc_write;
    logic             dc_valid_out;
    logic [CNT_W-1:0] dc_word_sel;
    logic [3:0]       dc_byte_w_en;
    logic             ram_req;
    logic             ram_write;
    logic [1:0]       ram_addr_sel;
    logic             stall;

    modport master (
        input  ic_read, dc_read, dc_write_in, ic_word_sel_in, dc_word_sel_in,
               dc_byte_w_en_in, ic_hit, ic_valid, dc_hit, dc_valid, dc_dirty, ram_ack,
        output ic_enable, ic_cmp, ic_write, ic_valid_out, ic_word_sel, ic_byte_w_en,
               ic_fill_src, dc_enable, dc_cmp, dc_write, dc_valid_out, dc_word_sel,
               dc_byte_w_en, ram_req, ram_write, ram_addr_sel, stall
    );

    modport slave (
        output ic_read, dc_read, dc_write_in, ic_word_sel_in, dc_word_sel_in,
               dc_byte_w_en_in, ic_hit, ic_valid, dc_hit, dc_valid, dc_dirty, ram_ack,
        input  ic_enable, ic_cmp, ic_write, ic_valid_out, ic_word_sel, ic_byte_w_en,
               ic_fill_src, dc_enable, dc_cmp, dc_write, dc_valid_out, dc_word_sel,
               dc_byte_w_en, ram_req, ram_write, ram_addr_sel, stall
    );

endinterface

// File: rtl/cache_miss_fsm_line_beat_counter.sv
// Word counter for one cache-line transfer; clear has priority over increment.
module line_beat_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    // Line length is a power of two, so the last word is the all-ones index.
    assign last = &cnt_q;

endmodule

// File: rtl/cache_miss_fsm.sv
// I/D-cache miss controller: write-back, D-cache fill and I-cache fill over a req/ack RAM port,
// stalling the pipeline while a miss is in service.
module cache_miss_fsm
    import cache_miss_fsm_pkg::*;
#(
    parameter int WORDS_PER_LINE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_miss_fsm_if.master  bus,
    output logic [2:0]        state
);

    localparam int CNT_W = $clog2(WORDS_PER_LINE);

    state_e           state_q;
    state_e           state_d;
    logic             pend_ic_q;
    logic             pend_ic_d;
    logic             cnt_clr;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             icm;
    logic             dcm;
    logic             ic_beat;

    line_beat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    assign icm = bus.ic_read & ~(bus.ic_hit & bus.ic_valid);
    assign dcm = (bus.dc_read | bus.dc_write_in) & ~(bus.dc_hit & bus.dc_valid);

    always_comb begin
        bus.ic_enable    = 1'b0;
        bus.ic_cmp       = 1'b0;
        bus.ic_write     = 1'b0;
        bus.ic_valid_out = 1'b0;
        bus.ic_word_sel  = '0;
        bus.ic_byte_w_en = 4'h0;
        bus.ic_fill_src  = 1'b0;
        bus.dc_enable    = 1'b0;
        bus.dc_cmp       = 1'b0;
        bus.dc_write     = 1'b0;
        bus.dc_valid_out = 1'b0;
        bus.dc_word_sel  = '0;
        bus.dc_byte_w_en = 4'h0;
        bus.ram_req      = 1'b0;
        bus.ram_write    = 1'b0;
        bus.ram_addr_sel = RAM_SEL_IC;
        bus.stall        = 1'b1;
        state_d          = state_q;
        pend_ic_d        = pend_ic_q;
        cnt_clr          = 1'b0;
        cnt_inc          = 1'b0;
        ic_beat          = 1'b0;

        case (state_q)
            ST_DC_WB: begin
                bus.dc_enable    = 1'b1;
                bus.dc_word_sel  = cnt;
                bus.ram_req      = 1'b1;
                bus.ram_write    = 1'b1;
                bus.ram_addr_sel = RAM_SEL_DC_WB;
                cnt_inc          = bus.ram_ack;
                if (bus.ram_ack && cnt_last) begin
                    state_d = ST_DC_FILL;
                    cnt_clr = 1'b1;
                end
            end

            ST_DC_FILL: begin
                bus.dc_enable    = 1'b1;
                bus.dc_valid_out = 1'b1;
                bus.dc_byte_w_en = 4'hF;
                bus.dc_word_sel  = cnt;
                bus.dc_write     = bus.ram_ack;
                bus.ram_req      = 1'b1;
                bus.ram_addr_sel = RAM_SEL_DC;
                cnt_inc          = bus.ram_ack;
                if (bus.ram_ack && cnt_last) begin
                    state_d   = pend_ic_q ? ST_IC_FILL : ST_NORMAL;
                    pend_ic_d = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end

            ST_IC_FILL: begin
                bus.ic_enable    = 1'b1;
                bus.ic_valid_out = 1'b1;
                bus.ic_byte_w_en = 4'hF;
                bus.ic_word_sel  = cnt;
                bus.dc_enable    = 1'b1;
                bus.dc_cmp       = 1'b1;
                bus.dc_word_sel  = cnt;
                // A D-cache hit on the fetched line supplies the word without touching RAM.
                if (bus.dc_hit && bus.dc_valid) begin
                    bus.ic_fill_src = 1'b1;
                    ic_beat         = 1'b1;
                end else begin
                    bus.ram_req      = 1'b1;
                    bus.ram_addr_sel = RAM_SEL_IC;
                    ic_beat          = bus.ram_ack;
                end
                bus.ic_write = ic_beat;
                cnt_inc      = ic_beat;
                if (ic_beat && cnt_last) begin
                    state_d = ST_NORMAL;
                    cnt_clr = 1'b1;
                end
            end

            default: begin
                bus.ic_enable    = bus.ic_read;
                bus.ic_cmp       = 1'b1;
                bus.ic_word_sel  = bus.ic_word_sel_in;
                bus.dc_enable    = bus.dc_read | bus.dc_write_in;
                bus.dc_cmp       = 1'b1;
                bus.dc_write     = bus.dc_write_in;
                bus.dc_word_sel  = bus.dc_word_sel_in;
                bus.dc_byte_w_en = bus.dc_byte_w_en_in;
                bus.stall        = icm | dcm;
                cnt_clr          = 1'b1;
                pend_ic_d        = icm & dcm;
                if (state_q != ST_NORMAL) begin
                    state_d   = ST_NORMAL;
                    pend_ic_d = 1'b0;
                end else if (dcm && bus.dc_dirty) begin
                    state_d = ST_DC_WB;
                end else if (dcm) begin
                    state_d = ST_DC_FILL;
                end else if (icm) begin
                    state_d = ST_IC_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_NORMAL;
            pend_ic_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_ic_q <= pend_ic_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cache_miss_fsm.sv
// Directed bench for cache_miss_fsm with 4-word lines.
module tb_cache_miss_fsm;

    localparam int WPL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    cache_miss_fsm_if #(.WORDS_PER_LINE(WPL)) bus ();

    cache_miss_fsm #(.WORDS_PER_LINE(WPL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (state)
    );

    task automatic clear_inputs();
        bus.ic_read = 0; bus.dc_read = 0; bus.dc_write_in = 0;
        bus.ic_word_sel_in = '0; bus.dc_word_sel_in = '0; bus.dc_byte_w_en_in = 4'h0;
        bus.ic_hit = 0; bus.ic_valid = 0; bus.dc_hit = 0; bus.dc_valid = 0;
        bus.dc_dirty = 0; bus.ram_ack = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        clear_inputs();
        rst_n = 0;
        #2;
        obs = {state, bus.ic_enable, bus.ic_write, bus.dc_enable, bus.dc_write,
               bus.ram_req, bus.ram_write, bus.stall};
        checks++;
        if (obs !== 10'd0 || bus.ram_addr_sel !== 2'b00) begin
            errors++; $display("FAIL reset_hold got %b sel %b want 0 sel 00", obs, bus.ram_addr_sel);
        end
        tick(); tick();
        @(negedge clk) rst_n = 1;
        tick();
        #2;
        obs = {state, bus.ic_enable, bus.ic_write, bus.dc_enable, bus.dc_write,
               bus.ram_req, bus.ram_write, bus.stall};
        checks++;
        if (obs !== 10'd0 || bus.ram_addr_sel !== 2'b00) begin
            errors++; $display("FAIL reset_release got %b sel %b want 0 sel 00", obs, bus.ram_addr_sel);
        end
        bus.ram_ack = 1;
        tick();
        #2;
        checks++;
        if ({state, bus.ram_req, bus.stall} !== 5'd0) begin
            errors++; $display("FAIL stray_ack got state %0d req %b stall %b want 0 0 0",
                               state, bus.ram_req, bus.stall);
        end
        bus.ram_ack = 0;
        $display("test_reset done");
    endtask

    task automatic test_ic_dc_combined();
        logic [9:0] obs;
        logic [9:0] exp;
        bus.ic_read = 1; bus.ic_hit = 0; bus.ic_valid = 1;
        bus.dc_read = 1; bus.dc_hit = 0; bus.dc_valid = 1; bus.dc_dirty = 1;
        #2;
        checks++;
        if ({state, bus.stall} !== 4'b0001) begin
            errors++; $display("FAIL combo_miss got state %0d stall %b want 0 1", state, bus.stall);
        end
        tick();
        bus.ic_read = 0; bus.dc_read = 0; bus.dc_dirty = 0;
        for (int k = 0; k < WPL; k++) begin
            bus.ram_ack = 1;
            #2;
            obs = {state, bus.ram_req, bus.ram_write, bus.ram_addr_sel, bus.stall, bus.dc_word_sel};
            exp = {3'd3, 1'b1, 1'b1, 2'b11, 1'b1, k[1:0]};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL combo_wb beat %0d got %b want %b", k, obs, exp);
            end
            tick();
        end
        for (int k = 0; k < WPL; k++) begin
            #2;
            obs = {state, bus.ram_req, bus.ram_write, bus.ram_addr_sel, bus.dc_write, bus.dc_word_sel};
            exp = {3'd2, 1'b1, 1'b0, 2'b01, 1'b1, k[1:0]};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL combo_dcfill beat %0d got %b want %b", k, obs, exp);
            end
            tick();
        end
        for (int k = 0; k < WPL; k++) begin
            #2;
            obs = {state, bus.ram_req, bus.ram_addr_sel, bus.ic_fill_src, bus.ic_write, bus.ic_word_sel};
            exp = {3'd1, 1'b1, 2'b00, 1'b0, 1'b1, k[1:0]};
            checks++;
            if (obs !== exp || bus.ic_valid_out !== 1'b1 || bus.ic_byte_w_en !== 4'hF) begin
                errors++; $display("FAIL combo_icfill beat %0d got %b vo %b be %h want %b vo 1 be f",
                                   k, obs, bus.ic_valid_out, bus.ic_byte_w_en, exp);
            end
            tick();
        end
        bus.ram_ack = 0;
        #2;
        checks++;
        if ({state, bus.stall} !== 4'b0000) begin
            errors++; $display("FAIL combo_end got state %0d stall %b want 0 0", state, bus.stall);
        end
        $display("test_ic_dc_combined done");
    endtask

    task automatic test_dc_clean_fill();
        logic [12:0] obs;
        logic [12:0] exp;
        int          pulses = 0;
        logic        ack;
        bus.dc_read = 1; bus.dc_hit = 0; bus.dc_valid = 1; bus.dc_dirty = 0;
        #2;
        checks++;
        if ({state, bus.stall, bus.dc_enable} !== 5'b00011) begin
            errors++; $display("FAIL clean_miss got state %0d stall %b en %b want 0 1 1",
                               state, bus.stall, bus.dc_enable);
        end
        tick();
        bus.dc_read = 0;
        for (int k = 0; k < 2 * WPL; k++) begin
            ack = k[0];
            bus.ram_ack = ack;
            #2;
            obs = {state, bus.stall, bus.ram_req, bus.ram_write, bus.ram_addr_sel,
                   bus.dc_word_sel[1:0], bus.dc_write, bus.dc_valid_out};
            exp = {3'd2, 1'b1, 1'b1, 1'b0, 2'b01, 2'(k / 2), ack, 1'b1};
            checks++;
            if (obs[11:0] !== exp[11:0] || bus.dc_byte_w_en !== 4'hF || bus.dc_cmp !== 1'b0) begin
                errors++; $display("FAIL clean_fill cyc %0d got %b be %h cmp %b want %b be f cmp 0",
                                   k, obs, bus.dc_byte_w_en, bus.dc_cmp, exp);
            end
            if (bus.dc_write === 1'b1) pulses++;
            tick();
        end
        bus.ram_ack = 0;
        #2;
        checks++;
        if ({state, bus.stall} !== 4'b0000) begin
            errors++; $display("FAIL clean_end got state %0d stall %b want 0 0", state, bus.stall);
        end
        checks++;
        if (pulses !== WPL) begin
            errors++; $display("FAIL clean_pulses got %0d want %0d", pulses, WPL);
        end
        $display("test_dc_clean_fill done");
    endtask

    task automatic test_dc_dirty_wb();
        logic [11:0] obs;
        logic [11:0] exp;
        bus.dc_write_in = 1; bus.dc_byte_w_en_in = 4'h3; bus.dc_word_sel_in = 2'd2;
        bus.dc_hit = 0; bus.dc_valid = 1; bus.dc_dirty = 1;
        #2;
        checks++;
        if ({bus.dc_write, bus.dc_cmp, bus.dc_byte_w_en, bus.dc_word_sel, bus.stall} !== 9'b1_1_0011_10_1) begin
            errors++; $display("FAIL store_pass got wr %b cmp %b be %h sel %0d stall %b want 1 1 3 2 1",
                               bus.dc_write, bus.dc_cmp, bus.dc_byte_w_en, bus.dc_word_sel, bus.stall);
        end
        tick();
        bus.dc_write_in = 0; bus.dc_dirty = 0; bus.dc_byte_w_en_in = 4'h0; bus.dc_word_sel_in = '0;
        bus.ram_ack = 0;
        #2;
        checks++;
        if ({state, bus.ram_req, bus.dc_word_sel} !== {3'd3, 1'b1, 2'd0}) begin
            errors++; $display("FAIL wb_wait got state %0d req %b sel %0d want 3 1 0",
                               state, bus.ram_req, bus.dc_word_sel);
        end
        tick();
        for (int k = 0; k < WPL; k++) begin
            bus.ram_ack = 1;
            #2;
            obs = {state, bus.ram_req, bus.ram_write, bus.ram_addr_sel, bus.dc_word_sel,
                   bus.dc_cmp, bus.dc_write, bus.dc_enable};
            exp = {3'd3, 1'b1, 1'b1, 2'b11, k[1:0], 1'b0, 1'b0, 1'b1};
            checks++;
            if (obs !== exp || bus.dc_byte_w_en !== 4'h0) begin
                errors++; $display("FAIL wb_beat %0d got %b be %h want %b be 0", k, obs, bus.dc_byte_w_en, exp);
            end
            tick();
        end
        for (int k = 0; k < WPL; k++) begin
            #2;
            obs = {state, bus.ram_req, bus.ram_write, bus.ram_addr_sel, bus.dc_word_sel,
                   bus.dc_cmp, bus.dc_write, bus.dc_enable};
            exp = {3'd2, 1'b1, 1'b0, 2'b01, k[1:0], 1'b0, 1'b1, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL wb_fill_beat %0d got %b want %b", k, obs, exp);
            end
            tick();
        end
        bus.ram_ack = 0;
        #2;
        checks++;
        if ({state, bus.stall, bus.ram_req} !== 5'd0) begin
            errors++; $display("FAIL wb_end got state %0d stall %b req %b want 0 0 0",
                               state, bus.stall, bus.ram_req);
        end
        $display("test_dc_dirty_wb done");
    endtask

    task automatic test_ic_from_dc();
        logic [11:0] obs;
        logic [11:0] exp;
        bus.ic_read = 1; bus.ic_hit = 0; bus.ic_valid = 0; bus.ic_word_sel_in = 2'd1;
        #2;
        checks++;
        if ({state, bus.ic_enable, bus.ic_cmp, bus.ic_word_sel, bus.stall} !== {3'd0, 1'b1, 1'b1, 2'd1, 1'b1}) begin
            errors++; $display("FAIL ic_miss got state %0d en %b cmp %b sel %0d stall %b want 0 1 1 1 1",
                               state, bus.ic_enable, bus.ic_cmp, bus.ic_word_sel, bus.stall);
        end
        tick();
        bus.ic_read = 0; bus.ic_word_sel_in = '0;
        bus.dc_hit = 1; bus.dc_valid = 1; bus.ram_ack = 0;
        for (int k = 0; k < WPL; k++) begin
            #2;
            obs = {state, bus.ram_req, bus.ic_write, bus.ic_fill_src, bus.ic_word_sel,
                   bus.dc_cmp, bus.dc_write, bus.dc_word_sel};
            exp = {3'd1, 1'b0, 1'b1, 1'b1, k[1:0], 1'b1, 1'b0, k[1:0]};
            checks++;
            if (obs !== exp || bus.dc_enable !== 1'b1) begin
                errors++; $display("FAIL ic_from_dc beat %0d got %b den %b want %b den 1",
                                   k, obs, bus.dc_enable, exp);
            end
            tick();
        end
        #2;
        checks++;
        if ({state, bus.stall, bus.ic_write} !== 5'd0) begin
            errors++; $display("FAIL ic_from_dc_end got state %0d stall %b wr %b want 0 0 0",
                               state, bus.stall, bus.ic_write);
        end
        bus.dc_hit = 0;
        $display("test_ic_from_dc done");
    endtask

    task automatic test_reset_mid_fill();
        bus.dc_read = 1; bus.dc_hit = 0; bus.dc_valid = 1; bus.dc_dirty = 0;
        tick();
        bus.dc_read = 0;
        bus.ram_ack = 1;
        tick(); tick();
        bus.ram_ack = 0;
        #2;
        checks++;
        if ({state, bus.ram_req, bus.dc_word_sel} !== {3'd2, 1'b1, 2'd2}) begin
            errors++; $display("FAIL mid_before got state %0d req %b sel %0d want 2 1 2",
                               state, bus.ram_req, bus.dc_word_sel);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({state, bus.ram_req, bus.stall, bus.dc_write} !== 6'd0) begin
            errors++; $display("FAIL mid_reset got state %0d req %b stall %b wr %b want 0 0 0 0",
                               state, bus.ram_req, bus.stall, bus.dc_write);
        end
        @(negedge clk) rst_n = 1;
        tick();
        bus.dc_read = 1;
        tick();
        bus.dc_read = 0;
        #2;
        checks++;
        if ({state, bus.dc_word_sel} !== {3'd2, 2'd0}) begin
            errors++; $display("FAIL mid_cnt_cleared got state %0d sel %0d want 2 0", state, bus.dc_word_sel);
        end
        bus.ram_ack = 1;
        for (int k = 0; k < WPL; k++) tick();
        bus.ram_ack = 0;
        #2;
        checks++;
        if ({state, bus.stall} !== 4'b0000) begin
            errors++; $display("FAIL mid_end got state %0d stall %b want 0 0", state, bus.stall);
        end
        $display("test_reset_mid_fill done");
    endtask

    initial begin
        test_reset();
        test_ic_dc_combined();
        test_dc_clean_fill();
        test_dc_dirty_wb();
        test_ic_from_dc();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
